result_framer: RTL and testbench

RESULT_FRAMER -- requirements
Module: result_framer

---
 rtl/result_framer_pkg.sv | 13 +
 rtl/result_framer_arith.sv | 36 +++
 rtl/result_framer.sv | 151 +++++++++++++++
 tb/tb_result_framer.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/result_framer_pkg.sv
// Shared constants and FSM state encoding for the result framer.
package result_framer_pkg;

  localparam int unsigned ZW = 8;
  localparam int unsigned XW = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/result_framer_arith.sv
// Arithmetic helpers for the framer: saturating adder and unsigned comparator.

module sat_add #(
  parameter int unsigned DATAWIDTH = 18
) (
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  output logic [DATAWIDTH-1:0] sum,
  output logic                 sat
);

  logic [DATAWIDTH:0] raw;

  // Add with one guard bit; clamp to all-ones on carry out.
  always_comb begin
    raw = {1'b0, a} + {1'b0, b};
    sat = raw[DATAWIDTH];
    sum = sat ? '1 : raw[DATAWIDTH-1:0];
  end

endmodule

module COMP #(
  parameter int unsigned DATAWIDTH = 8
) (
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  output logic                 gt
);

  // Unsigned strict greater-than.
  always_comb begin
    gt = (a > b);
  end

endmodule

// File: rtl/result_framer.sv
// Collects FRAME_LEN (z, x) result pairs into one summary: saturating sum of x,
// unsigned max of z and a sticky saturation flag, held until downstream takes it.
module result_framer
  import result_framer_pkg::*;
#(
  parameter int unsigned FRAME_LEN = 8,
  parameter int unsigned ZW        = result_framer_pkg::ZW,
  parameter int unsigned XW        = result_framer_pkg::XW,
  parameter int unsigned SUMW      = 18
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [ZW-1:0]   z,
  input  logic [XW-1:0]   x,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SUMW-1:0] out_sum,
  output logic [ZW-1:0]   out_zmax,
  output logic            out_sat
);

  localparam logic [7:0] FL = 8'(FRAME_LEN);

  state_e          state_q, state_d;
  logic [7:0]      acc_cnt_q, acc_cnt_d;
  logic [7:0]      abs_cnt_q, abs_cnt_d;
  logic            pend_q, pend_d;
  logic [ZW-1:0]   zal_q, zal_d;
  logic [SUMW-1:0] acc_q, acc_d;
  logic [ZW-1:0]   zmax_q, zmax_d;
  logic            sat_q, sat_d;
  logic [SUMW-1:0] osum_q, osum_d;
  logic [ZW-1:0]   ozmax_q, ozmax_d;
  logic            osat_q, osat_d;

  logic            accept;
  logic            last_abs;
  logic [SUMW-1:0] add_sum;
  logic            add_sat;
  logic            z_gt;

  sat_add #(.DATAWIDTH(SUMW)) u_sat_add (
    .a  (acc_q),
    .b  (SUMW'(x)),
    .sum(add_sum),
    .sat(add_sat)
  );

  COMP #(.DATAWIDTH(ZW)) u_comp (
    .a (zal_q),
    .b (zmax_q),
    .gt(z_gt)
  );

  // Handshakes, absorption of the aligned sample, FSM next state and summary capture.
  always_comb begin
    in_ready  = (state_q != HOLD) && (acc_cnt_q < FL);
    accept    = in_valid && in_ready;
    out_valid = (state_q == HOLD);
    last_abs  = pend_q && (abs_cnt_q == FL - 8'd1);

    state_d   = state_q;
    acc_cnt_d = acc_cnt_q;
    abs_cnt_d = abs_cnt_q;
    pend_d    = accept;
    zal_d     = zal_q;
    acc_d     = acc_q;
    zmax_d    = zmax_q;
    sat_d     = sat_q;
    osum_d    = osum_q;
    ozmax_d   = ozmax_q;
    osat_d    = osat_q;

    if (accept) begin
      zal_d     = z;
      acc_cnt_d = acc_cnt_q + 8'd1;
    end

    // x arrives one cycle after its z, so it is only meaningful while pending.
    if (pend_q) begin
      acc_d     = add_sum;
      zmax_d    = z_gt ? zal_q : zmax_q;
      abs_cnt_d = abs_cnt_q + 8'd1;
      sat_d     = sat_q | add_sat;
    end

    unique case (state_q)
      // A single-sample frame stays in IDLE until that sample is absorbed.
      IDLE: begin
        if (last_abs) state_d = HOLD;
        else if (accept && FL != 8'd1) state_d = ACCUM;
      end
      ACCUM: begin
        if (last_abs) state_d = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          state_d   = IDLE;
          acc_d     = '0;
          zmax_d    = '0;
          sat_d     = 1'b0;
          acc_cnt_d = '0;
          abs_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d == HOLD && state_q != HOLD) begin
      osum_d  = acc_d;
      ozmax_d = zmax_d;
      osat_d  = sat_d;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_cnt_q <= '0;
      abs_cnt_q <= '0;
      pend_q    <= 1'b0;
      zal_q     <= '0;
      acc_q     <= '0;
      zmax_q    <= '0;
      sat_q     <= 1'b0;
      osum_q    <= '0;
      ozmax_q   <= '0;
      osat_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_cnt_q <= acc_cnt_d;
      abs_cnt_q <= abs_cnt_d;
      pend_q    <= pend_d;
      zal_q     <= zal_d;
      acc_q     <= acc_d;
      zmax_q    <= zmax_d;
      sat_q     <= sat_d;
      osum_q    <= osum_d;
      ozmax_q   <= ozmax_d;
      osat_q    <= osat_d;
    end
  end

  assign out_sum  = osum_q;
  assign out_zmax = ozmax_q;
  assign out_sat  = osat_q;

endmodule

// File: tb/tb_result_framer.sv
// Bench for result_framer: four instances (FRAME_LEN 4, 8, 2, 1) driven one at a time.
module tb_result_framer;

  typedef struct packed {
    logic [17:0] sum;
    logic [7:0]  zmax;
    logic        sat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid  [4];
  logic        in_ready  [4];
  logic        out_valid [4];
  logic        out_ready [4];
  logic        out_sat   [4];
  logic [7:0]  z         [4];
  logic [15:0] x         [4];
  logic [17:0] out_sum   [4];
  logic [7:0]  out_zmax  [4];

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int unsigned FL = (g == 0) ? 4 : (g == 1) ? 8 : (g == 2) ? 2 : 1;
    result_framer #(.FRAME_LEN(FL), .ZW(8), .XW(16), .SUMW(18)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .z        (z[g]),
      .x        (x[g]),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .out_sum  (out_sum[g]),
      .out_zmax (out_zmax[g]),
      .out_sat  (out_sat[g])
    );
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference behaviour of one frame.
  function automatic exp_t model(input int n, input logic [7:0] zs[8], input logic [15:0] xs[8]);
    exp_t e;
    int   s;
    e = '0;
    s = 0;
    for (int i = 0; i < n; i++) begin
      s = s + int'(xs[i]);
      if (s > 262143) begin
        s = 262143;
        e.sat = 1'b1;
      end
      if (zs[i] > e.zmax) e.zmax = zs[i];
    end
    e.sum = 18'(s);
    return e;
  endfunction

  // Offers n samples to instance k (gap idle cycles after each accept), supplying x
  // the cycle after each acceptance and junk x otherwise. Returns after the last x.
  task automatic drive(input int k, input int n, input logic [7:0] zs[8],
                       input logic [15:0] xs[8], input int gap,
                       output int cycles, output logic ov_before);
    int          i = 0;
    int          gcnt = 0;
    logic        have_x = 1'b0;
    logic [15:0] px = '0;
    logic        acc;
    cycles = 0;
    ov_before = 1'b1;
    while ((i < n || have_x) && cycles < 200) begin
      in_valid[k] = (i < n) && (gcnt == 0);
      z[k] = 8'($urandom);
      if (i < n) z[k] = zs[i];
      x[k] = have_x ? px : 16'($urandom);
      acc = in_valid[k] && in_ready[k];
      step();
      cycles++;
      have_x = acc;
      if (acc) begin
        px = xs[i];
        i++;
        gcnt = gap;
        if (i == n) ov_before = out_valid[k];
      end else if (gcnt > 0) begin
        gcnt--;
      end
    end
    in_valid[k] = 1'b0;
    if (i < n || have_x) begin
      errors++;
      $display("FAIL drive_timeout inst %0d got %0d accepts want %0d", k, i, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_valid[k] = 1'b0; out_ready[k] = 1'b1; z[k] = '0; x[k] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (in_ready[k] !== 1'b1) begin errors++; $display("FAIL reset_in_ready[%0d] got %b want 1", k, in_ready[k]); end
      checks++; if (out_valid[k] !== 1'b0) begin errors++; $display("FAIL reset_out_valid[%0d] got %b want 0", k, out_valid[k]); end
      checks++; if (out_sum[k] !== 18'd0) begin errors++; $display("FAIL reset_out_sum[%0d] got %0d want 0", k, out_sum[k]); end
      checks++; if (out_zmax[k] !== 8'd0) begin errors++; $display("FAIL reset_out_zmax[%0d] got %0d want 0", k, out_zmax[k]); end
      checks++; if (out_sat[k] !== 1'b0) begin errors++; $display("FAIL reset_out_sat[%0d] got %b want 0", k, out_sat[k]); end
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    logic [7:0]  zs[8];
    logic [15:0] xs[8];
    int cyc; logic ovb; exp_t e;
    zs = '{3, 9, 1, 7, 0, 0, 0, 0};
    xs = '{10, 20, 30, 40, 0, 0, 0, 0};
    sb.push_back(exp_t'{18'd100, 8'd9, 1'b0});
    drive(0, 4, zs, xs, 0, cyc, ovb);
    checks++; if (cyc != 5) begin errors++; $display("FAIL basic_cycles got %0d want 5", cyc); end
    checks++; if (ovb !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %b want 0", ovb); end
    checks++; if (out_valid[0] !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", out_valid[0]); end
    if (sb.size() == 0) begin errors++; $display("FAIL basic_scoreboard got empty want entry"); end
    else begin
      e = sb.pop_front();
      checks++; if (out_sum[0] !== e.sum) begin errors++; $display("FAIL basic_sum got %0d want %0d", out_sum[0], e.sum); end
      checks++; if (out_zmax[0] !== e.zmax) begin errors++; $display("FAIL basic_zmax got %0d want %0d", out_zmax[0], e.zmax); end
      checks++; if (out_sat[0] !== e.sat) begin errors++; $display("FAIL basic_sat got %b want %b", out_sat[0], e.sat); end
    end
    step();
    checks++; if (out_valid[0] !== 1'b0) begin errors++; $display("FAIL basic_release_valid got %b want 0", out_valid[0]); end
    checks++; if (in_ready[0] !== 1'b1) begin errors++; $display("FAIL basic_release_ready got %b want 1", in_ready[0]); end
  endtask

  task automatic test_saturation();
    logic [7:0]  zs[8];
    logic [15:0] xs[8];
    int cyc; logic ovb; exp_t e; logic [7:0] zm;
    zm = '0;
    for (int i = 0; i < 8; i++) begin
      zs[i] = 8'($urandom);
      xs[i] = 16'hFFFF;
      if (zs[i] > zm) zm = zs[i];
    end
    sb.push_back(exp_t'{18'd262143, zm, 1'b1});
    drive(1, 8, zs, xs, 0, cyc, ovb);
    checks++; if (out_valid[1] !== 1'b1) begin errors++; $display("FAIL sat_valid got %b want 1", out_valid[1]); end
    if (sb.size() == 0) begin errors++; $display("FAIL sat_scoreboard got empty want entry"); end
    else begin
      e = sb.pop_front();
      checks++; if (out_sum[1] !== e.sum) begin errors++; $display("FAIL sat_sum got %0d want %0d", out_sum[1], e.sum); end
      checks++; if (out_zmax[1] !== e.zmax) begin errors++; $display("FAIL sat_zmax got %0d want %0d", out_zmax[1], e.zmax); end
      checks++; if (out_sat[1] !== e.sat) begin errors++; $display("FAIL sat_flag got %b want %b", out_sat[1], e.sat); end
    end
    step();
  endtask

  task automatic test_hold_backpressure();
    logic [7:0]  zs[8];
    logic [15:0] xs[8];
    int cyc; logic ovb; exp_t e;
    for (int i = 0; i < 8; i++) begin zs[i] = 8'($urandom); xs[i] = 16'($urandom_range(0, 5000)); end
    out_ready[0] = 1'b0;
    e = model(4, zs, xs);
    sb.push_back(e);
    drive(0, 4, zs, xs, 0, cyc, ovb);
    e = sb.pop_front();
    for (int c = 0; c < 5; c++) begin
      checks++; if (out_valid[0] !== 1'b1) begin errors++; $display("FAIL hold_valid c%0d got %b want 1", c, out_valid[0]); end
      checks++; if (in_ready[0] !== 1'b0) begin errors++; $display("FAIL hold_ready c%0d got %b want 0", c, in_ready[0]); end
      checks++; if (out_sum[0] !== e.sum) begin errors++; $display("FAIL hold_sum c%0d got %0d want %0d", c, out_sum[0], e.sum); end
      checks++; if (out_zmax[0] !== e.zmax) begin errors++; $display("FAIL hold_zmax c%0d got %0d want %0d", c, out_zmax[0], e.zmax); end
      checks++; if (out_sat[0] !== e.sat) begin errors++; $display("FAIL hold_sat c%0d got %b want %b", c, out_sat[0], e.sat); end
      in_valid[0] = 1'b1;
      z[0] = 8'hFF;
      x[0] = 16'($urandom);
      step();
    end
    out_ready[0] = 1'b1;
    step();
    in_valid[0] = 1'b0;
    checks++; if (out_valid[0] !== 1'b0) begin errors++; $display("FAIL hold_release_valid got %b want 0", out_valid[0]); end
    checks++; if (in_ready[0] !== 1'b1) begin errors++; $display("FAIL hold_release_ready got %b want 1", in_ready[0]); end
    // A stray accept during HOLD would corrupt this following frame.
    for (int i = 0; i < 8; i++) begin zs[i] = 8'($urandom_range(0, 100)); xs[i] = 16'($urandom_range(0, 5000)); end
    sb.push_back(model(4, zs, xs));
    drive(0, 4, zs, xs, 0, cyc, ovb);
    e = sb.pop_front();
    checks++; if (out_valid[0] !== 1'b1) begin errors++; $display("FAIL hold_next_valid got %b want 1", out_valid[0]); end
    checks++; if (out_sum[0] !== e.sum) begin errors++; $display("FAIL hold_next_sum got %0d want %0d", out_sum[0], e.sum); end
    checks++; if (out_zmax[0] !== e.zmax) begin errors++; $display("FAIL hold_next_zmax got %0d want %0d", out_zmax[0], e.zmax); end
    step();
  endtask

  task automatic test_gapped();
    logic [7:0]  zs[8];
    logic [15:0] xs[8];
    int cyc; logic ovb; exp_t e;
    zs = '{4, 2, 0, 0, 0, 0, 0, 0};
    xs = '{5, 6, 0, 0, 0, 0, 0, 0};
    sb.push_back(exp_t'{18'd11, 8'd4, 1'b0});
    drive(2, 2, zs, xs, 2, cyc, ovb);
    checks++; if (cyc != 5) begin errors++; $display("FAIL gap_cycles got %0d want 5", cyc); end
    checks++; if (ovb !== 1'b0) begin errors++; $display("FAIL gap_early_valid got %b want 0", ovb); end
    checks++; if (out_valid[2] !== 1'b1) begin errors++; $display("FAIL gap_valid got %b want 1", out_valid[2]); end
    e = sb.pop_front();
    checks++; if (out_sum[2] !== e.sum) begin errors++; $display("FAIL gap_sum got %0d want %0d", out_sum[2], e.sum); end
    checks++; if (out_zmax[2] !== e.zmax) begin errors++; $display("FAIL gap_zmax got %0d want %0d", out_zmax[2], e.zmax); end
    step();
  endtask

  task automatic test_reset_midframe();
    logic [7:0]  zs[8];
    logic [15:0] xs[8];
    int cyc; logic ovb; exp_t e;
    zs = '{200, 200, 0, 0, 0, 0, 0, 0};
    xs = '{5000, 5000, 0, 0, 0, 0, 0, 0};
    drive(0, 2, zs, xs, 0, cyc, ovb);
    rst = 1'b1;
    #1;
    checks++; if (in_ready[0] !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b want 1", in_ready[0]); end
    checks++; if (out_valid[0] !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", out_valid[0]); end
    step();
    rst = 1'b0;
    zs = '{1, 2, 3, 4, 0, 0, 0, 0};
    xs = '{1, 1, 1, 1, 0, 0, 0, 0};
    sb.push_back(exp_t'{18'd4, 8'd4, 1'b0});
    drive(0, 4, zs, xs, 0, cyc, ovb);
    checks++; if (ovb !== 1'b0) begin errors++; $display("FAIL midrst_early_valid got %b want 0", ovb); end
    checks++; if (out_valid[0] !== 1'b1) begin errors++; $display("FAIL midrst_frame_valid got %b want 1", out_valid[0]); end
    e = sb.pop_front();
    checks++; if (out_sum[0] !== e.sum) begin errors++; $display("FAIL midrst_sum got %0d want %0d", out_sum[0], e.sum); end
    checks++; if (out_zmax[0] !== e.zmax) begin errors++; $display("FAIL midrst_zmax got %0d want %0d", out_zmax[0], e.zmax); end
    step();
  endtask

  task automatic test_fl1();
    logic [7:0]  zs[8];
    logic [15:0] xs[8];
    int cyc; logic ovb; exp_t e;
    zs = '{255, 0, 0, 0, 0, 0, 0, 0};
    xs = '{0, 0, 0, 0, 0, 0, 0, 0};
    sb.push_back(exp_t'{18'd0, 8'd255, 1'b0});
    drive(3, 1, zs, xs, 0, cyc, ovb);
    checks++; if (cyc != 2) begin errors++; $display("FAIL fl1_cycles got %0d want 2", cyc); end
    checks++; if (ovb !== 1'b0) begin errors++; $display("FAIL fl1_early_valid got %b want 0", ovb); end
    checks++; if (out_valid[3] !== 1'b1) begin errors++; $display("FAIL fl1_valid got %b want 1", out_valid[3]); end
    e = sb.pop_front();
    checks++; if (out_sum[3] !== e.sum) begin errors++; $display("FAIL fl1_sum got %0d want %0d", out_sum[3], e.sum); end
    checks++; if (out_zmax[3] !== e.zmax) begin errors++; $display("FAIL fl1_zmax got %0d want %0d", out_zmax[3], e.zmax); end
    step();
    // Reset while a summary is held must drop it.
    out_ready[3] = 1'b0;
    zs[0] = 8'd17;
    xs[0] = 16'd99;
    sb.push_back(model(1, zs, xs));
    drive(3, 1, zs, xs, 0, cyc, ovb);
    e = sb.pop_front();
    checks++; if (out_sum[3] !== e.sum) begin errors++; $display("FAIL fl1_hold_sum got %0d want %0d", out_sum[3], e.sum); end
    rst = 1'b1;
    #1;
    checks++; if (out_valid[3] !== 1'b0) begin errors++; $display("FAIL fl1_rst_valid got %b want 0", out_valid[3]); end
    checks++; if (out_sum[3] !== 18'd0) begin errors++; $display("FAIL fl1_rst_sum got %0d want 0", out_sum[3]); end
    checks++; if (out_zmax[3] !== 8'd0) begin errors++; $display("FAIL fl1_rst_zmax got %0d want 0", out_zmax[3]); end
    step();
    rst = 1'b0;
    out_ready[3] = 1'b1;
    step();
    step();
    checks++; if (out_valid[3] !== 1'b0) begin errors++; $display("FAIL fl1_post_rst_valid got %b want 0", out_valid[3]); end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  zs[8];
    logic [15:0] xs[8];
    int cyc; logic ovb; exp_t e;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 8; i++) begin zs[i] = 8'($urandom); xs[i] = 16'($urandom); end
      sb.push_back(model(8, zs, xs));
      drive(1, 8, zs, xs, 0, cyc, ovb);
      // The second frame starts while the first is still held: one refused cycle.
      checks++; if (cyc != ((f == 0) ? 9 : 10)) begin errors++; $display("FAIL b2b_cycles f%0d got %0d want %0d", f, cyc, (f == 0) ? 9 : 10); end
      checks++; if (out_valid[1] !== 1'b1) begin errors++; $display("FAIL b2b_valid f%0d got %b want 1", f, out_valid[1]); end
      e = sb.pop_front();
      checks++; if (out_sum[1] !== e.sum) begin errors++; $display("FAIL b2b_sum f%0d got %0d want %0d", f, out_sum[1], e.sum); end
      checks++; if (out_zmax[1] !== e.zmax) begin errors++; $display("FAIL b2b_zmax f%0d got %0d want %0d", f, out_zmax[1], e.zmax); end
      checks++; if (out_sat[1] !== e.sat) begin errors++; $display("FAIL b2b_sat f%0d got %b want %b", f, out_sat[1], e.sat); end
    end
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_hold_backpressure();
    test_gapped();
    test_reset_midframe();
    test_fl1();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
